// File: rtl/router_register.sv
// router_register: input-side byte register of the 1x3 packet router.
// Latches the header, forwards header/payload/parity bytes to the FIFOs,
// holds the byte that arrives while the destination FIFO is full, and
// checks the running XOR parity against the received parity byte.
module router_register (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic       fifo_full,
  input  logic       detect_add,
  input  logic       lfd_state,
  input  logic       ld_state,
  input  logic       laf_state,
  input  logic       full_state,
  input  logic       rst_int_reg,
  input  logic [7:0] data_in,
  output logic       parity_done,
  output logic       low_pkt_valid,
  output logic       err,
  output logic [7:0] data_out
);

  logic [7:0] header_byte;
  logic [7:0] full_byte;
  logic [7:0] int_parity;
  logic [7:0] pkt_parity;
  logic       par_cap;

  // The parity byte is taken either straight off the stream in LOAD_DATA or,
  // if the FIFO was full when pkt_valid dropped, once LOAD_AFTER_FULL runs.
  assign par_cap = (ld_state & ~fifo_full & ~pkt_valid)
                 | (laf_state & low_pkt_valid & ~parity_done);

  // Header capture; address 3 is not a valid destination and is ignored.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      header_byte <= '0;
    else if (detect_add && pkt_valid && (data_in[1:0] != 2'b11))
      header_byte <= data_in;
  end

  // Byte held while the FIFO is full; the last such byte wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      full_byte <= '0;
    else if (ld_state && fifo_full)
      full_byte <= data_in;
  end

  // Output byte mux toward the FIFOs, one cycle of latency.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      data_out <= '0;
    else if (lfd_state)
      data_out <= header_byte;
    else if (ld_state && !fifo_full)
      data_out <= data_in;
    else if (laf_state)
      data_out <= full_byte;
  end

  // Running XOR of header and payload; the parity byte itself is excluded.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      int_parity <= '0;
    else if (detect_add)
      int_parity <= '0;
    else if (lfd_state)
      int_parity <= int_parity ^ header_byte;
    else if (ld_state && pkt_valid && !full_state && !fifo_full)
      int_parity <= int_parity ^ data_in;
  end

  // Received parity byte and its capture flag load on the same edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pkt_parity  <= '0;
      parity_done <= 1'b0;
    end else if (detect_add) begin
      pkt_parity  <= '0;
      parity_done <= 1'b0;
    end else if (par_cap) begin
      pkt_parity  <= data_in;
      parity_done <= 1'b1;
    end
  end

  // Remembers that pkt_valid dropped during LOAD_DATA until the FSM clears it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      low_pkt_valid <= 1'b0;
    else if (rst_int_reg)
      low_pkt_valid <= 1'b0;
    else if (ld_state && !pkt_valid)
      low_pkt_valid <= 1'b1;
  end

  // Parity compare, evaluated once parity_done is visible and then sticky.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      err <= 1'b0;
    else if (detect_add)
      err <= 1'b0;
    else if (parity_done)
      err <= (int_parity != pkt_parity);
  end

endmodule

// File: tb/tb_router_register.sv
// Directed bench for router_register: reset, good/bad parity packets,
// full-FIFO hold, late parity capture and invalid-address header.
module tb_router_register;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pkt_valid, fifo_full, detect_add, lfd_state, ld_state;
  logic       laf_state, full_state, rst_int_reg;
  logic [7:0] data_in;
  logic       parity_done, low_pkt_valid, err;
  logic [7:0] data_out;

  int total = 0;
  int bad   = 0;

  router_register dut (
    .clk           (clk),
    .resetn        (resetn),
    .pkt_valid     (pkt_valid),
    .fifo_full     (fifo_full),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .data_in       (data_in),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .err           (err),
    .data_out      (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    pkt_valid = 0; fifo_full = 0; detect_add = 0; lfd_state = 0; ld_state = 0;
    laf_state = 0; full_state = 0; rst_int_reg = 0; data_in = 8'h00;
  endtask

  // advance one rising edge and settle for sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive a full packet with header 8'h51 and 20 payload bytes;
  // flip selects a corrupted parity byte
  task automatic run_packet(input logic flip, input string nm);
    logic [7:0] par;
    logic [7:0] b;
    idle(); rst_int_reg = 1; tick();
    idle(); detect_add = 1; pkt_valid = 1; data_in = 8'h51; tick();
    chk({nm, "_pd_clr"}, {7'b0, parity_done}, 8'h00);
    idle(); lfd_state = 1; tick();
    chk({nm, "_hdr"}, data_out, 8'h51);
    par = 8'h51;
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom_range(0, 255));
      par = par ^ b;
      idle(); ld_state = 1; pkt_valid = 1; data_in = b; tick();
      chk($sformatf("%s_pay%0d", nm, i), data_out, b);
    end
    idle(); ld_state = 1; pkt_valid = 0; data_in = par ^ {7'b0, flip}; tick();
    chk({nm, "_par_out"}, data_out, par ^ {7'b0, flip});
    chk({nm, "_pd"}, {7'b0, parity_done}, 8'h01);
    chk({nm, "_err_early"}, {7'b0, err}, 8'h00);
    idle(); tick();
    chk({nm, "_err"}, {7'b0, err}, {7'b0, flip});
  endtask

  initial begin
    idle();
    resetn = 0;
    #12;
    chk("rst_dout", data_out, 8'h00);
    chk("rst_pd", {7'b0, parity_done}, 8'h00);
    chk("rst_lpv", {7'b0, low_pkt_valid}, 8'h00);
    chk("rst_err", {7'b0, err}, 8'h00);
    resetn = 1;
    tick();

    // 1: asynchronous reset mid-packet
    idle(); detect_add = 1; pkt_valid = 1; data_in = 8'h42; tick();
    idle(); lfd_state = 1; tick();
    chk("mid_hdr", data_out, 8'h42);
    idle(); ld_state = 1; pkt_valid = 0; data_in = 8'h77; tick();
    chk("mid_lpv", {7'b0, low_pkt_valid}, 8'h01);
    #2 resetn = 0;
    #1;
    chk("arst_dout", data_out, 8'h00);
    chk("arst_pd", {7'b0, parity_done}, 8'h00);
    chk("arst_lpv", {7'b0, low_pkt_valid}, 8'h00);
    #1 resetn = 1;
    idle(); lfd_state = 1; tick();
    chk("arst_hdr_clr", data_out, 8'h00);

    // 2 and 3: good and corrupted parity
    run_packet(1'b0, "good");
    run_packet(1'b1, "badpar");

    // 4: full hold, then emit held byte; 5: late parity capture
    idle(); rst_int_reg = 1; tick();
    idle(); detect_add = 1; pkt_valid = 1; data_in = 8'h0A; tick();
    chk("full_err_clr", {7'b0, err}, 8'h00);
    idle(); lfd_state = 1; tick();
    chk("full_hdr", data_out, 8'h0A);
    idle(); ld_state = 1; pkt_valid = 1; data_in = 8'h11; tick();
    chk("full_b0", data_out, 8'h11);
    idle(); ld_state = 1; fifo_full = 1; pkt_valid = 1; data_in = 8'h3C; tick();
    chk("full_hold0", data_out, 8'h11);
    idle(); ld_state = 1; fifo_full = 1; pkt_valid = 0; data_in = 8'hA5; tick();
    chk("full_hold1", data_out, 8'h11);
    chk("full_lpv", {7'b0, low_pkt_valid}, 8'h01);
    chk("full_pd0", {7'b0, parity_done}, 8'h00);
    // int_parity = 0A ^ 11 = 1B; send matching parity during LOAD_AFTER_FULL
    idle(); laf_state = 1; data_in = 8'h1B; tick();
    chk("laf_dout", data_out, 8'hA5);
    chk("laf_pd", {7'b0, parity_done}, 8'h01);
    idle(); laf_state = 1; data_in = 8'hFF; tick();
    chk("laf_err", {7'b0, err}, 8'h00);
    idle(); rst_int_reg = 1; tick();
    chk("rst_int_lpv", {7'b0, low_pkt_valid}, 8'h00);
    chk("rst_int_err", {7'b0, err}, 8'h00);

    // late capture with wrong parity flags err
    idle(); detect_add = 1; pkt_valid = 1; data_in = 8'h0A; tick();
    idle(); lfd_state = 1; tick();
    idle(); ld_state = 1; fifo_full = 1; pkt_valid = 0; data_in = 8'h66; tick();
    idle(); laf_state = 1; data_in = 8'h00; tick();
    chk("laf2_dout", data_out, 8'h66);
    idle(); tick();
    chk("laf2_err", {7'b0, err}, 8'h01);

    // 6: address 3 header is ignored
    idle(); detect_add = 1; pkt_valid = 1; data_in = 8'h53; tick();
    chk("inv_pd_clr", {7'b0, parity_done}, 8'h00);
    chk("inv_err_clr", {7'b0, err}, 8'h00);
    idle(); lfd_state = 1; tick();
    chk("inv_hdr_kept", data_out, 8'h0A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
